// File: rtl/denorm_seq.sv
// denorm_seq: right-shifts an intermediate fraction into the subnormal range, SHF_STEP bits per cycle,
// collecting the shifted-out bits into a sticky flag behind a valid/ready handshake.
module denorm_seq #(
   parameter int SHF_STEP = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [74:0] frac_in,
   input  logic [9:0]  exp_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [74:0] frac_out,
   output logic        denorm_m,
   output logic        sticky_out,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [4:0] STEP = 5'(SHF_STEP);
   state_t      r_state;
   logic [4:0]  r_rem;
   logic [74:0] r_frac;
   logic        r_denorm;
   logic        r_sticky;
   logic        r_out_valid;
   logic        r_busy;
   logic        r_in_ready;
   logic [9:0]  w_diff;
   logic [4:0]  w_cnt;
   logic [4:0]  w_step;
   logic [74:0] w_mask;
   // 10'h382 is -126; the subtraction wraps in 10 bits
   assign w_diff = 10'h382 - exp_in;
   assign w_cnt  = ($signed(w_diff) <= 10'sd0) ? 5'd0 :
                   ($signed(w_diff) > 10'sd27) ? 5'd27 : w_diff[4:0];
   assign w_step = (r_rem < STEP) ? r_rem : STEP;
   assign w_mask = ~({75{1'b1}} << w_step);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rem       <= 5'd0;
         r_frac      <= '0;
         r_denorm    <= 1'b0;
         r_sticky    <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_frac      <= frac_in;
               r_sticky    <= 1'b0;
               r_denorm    <= |w_cnt;
               r_rem       <= w_cnt;
               r_in_ready  <= 1'b0;
               r_busy      <= 1'b1;
               r_out_valid <= ~|w_cnt;
               r_state     <= (|w_cnt) ? SHIFT : DONE;
            end
            SHIFT: begin
               r_frac   <= r_frac >> w_step;
               r_sticky <= r_sticky | (|(r_frac & w_mask));
               r_rem    <= r_rem - w_step;
               if (r_rem == w_step) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign busy       = r_busy;
   assign frac_out   = r_frac;
   assign denorm_m   = r_denorm;
   assign sticky_out = r_sticky;
endmodule

// File: tb/tb_denorm_seq.sv
// tb_denorm_seq: scoreboard bench for denorm_seq with directed corner cases and randomized traffic.
module tb_denorm_seq;
   localparam int STEP = 8;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [74:0] frac_in = '0;
   logic [9:0]  exp_in = '0;
   logic        in_ready, out_valid, denorm_m, sticky_out, busy;
   logic [74:0] frac_out;
   typedef struct {
      logic [74:0] frac;
      logic        dn;
      logic        st;
      int          lat;
      int          acc;
   } sb_t;
   sb_t q[$];
   int  chks = 0, errs = 0, cyc = 0, n_acc = 0;
   bit  bp = 0;

   denorm_seq #(.SHF_STEP(STEP)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .frac_in(frac_in), .exp_in(exp_in), .out_valid(out_valid), .out_ready(out_ready),
      .frac_out(frac_out), .denorm_m(denorm_m), .sticky_out(sticky_out), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", chks, errs);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
      chks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // reference: exponent distance below -126 in 10-bit wraparound, capped at 27
   function automatic sb_t model(input logic [74:0] f, input logic [9:0] e, input int c);
      sb_t r;
      int  d, sc;
      d = -126 - int'($signed(e));
      d = ((d % 1024) + 1024) % 1024;
      if (d >= 512) d -= 1024;
      sc = (d <= 0) ? 0 : ((d > 27) ? 27 : d);
      r.frac = f >> sc;
      r.st = 1'b0;
      for (int i = 0; i < sc; i++) r.st |= f[i];
      r.dn = (sc != 0);
      r.lat = (sc == 0) ? 1 : 1 + (sc + STEP - 1) / STEP;
      r.acc = c;
      return r;
   endfunction

   always @(posedge clk) begin
      if (!rst && in_valid && in_ready) begin
         q.push_back(model(frac_in, exp_in, cyc));
         n_acc++;
      end
      cyc++;
   end

   always @(posedge clk) if (bp) begin
      #1;
      out_ready = ($urandom_range(0, 2) != 0);
   end

   bit          pv = 0, held = 0;
   logic [76:0] snap;
   sb_t         e;
   always @(negedge clk) begin
      if (rst) begin
         pv = 0;
         held = 0;
      end else begin
         if (held) begin
            chk("hold_valid", 80'(out_valid), 80'(1));
            chk("hold_data", 80'({frac_out, denorm_m, sticky_out}), 80'(snap));
         end
         if (out_valid && !pv) begin
            if (q.size() == 0) chk("unexpected_valid_queue", 80'(q.size()), 80'(1));
            else chk("latency", 80'(cyc - q[0].acc), 80'(q[0].lat));
         end
         if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("frac_out", 80'(frac_out), 80'(e.frac));
            chk("denorm_m", 80'(denorm_m), 80'(e.dn));
            chk("sticky_out", 80'(sticky_out), 80'(e.st));
         end
         held = out_valid && !out_ready;
         snap = {frac_out, denorm_m, sticky_out};
         pv = out_valid;
      end
   end

   task automatic send(input logic [74:0] f, input logic [9:0] x);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("send_timeout", 80'(n < 300), 80'(1));
      in_valid = 1'b1;
      frac_in = f;
      exp_in = x;
      @(negedge clk);
      in_valid = 1'b0;
      frac_in = {$urandom, $urandom, 11'($urandom)};
      exp_in = 10'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() > 0 || out_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue", 80'(q.size()), 80'(0));
   endtask

   initial begin
      int          n, k;
      logic [74:0] f;
      logic [9:0]  x;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 80'(out_valid), 80'(0));
      chk("rst_busy", 80'(busy), 80'(0));
      chk("rst_in_ready", 80'(in_ready), 80'(1));
      chk("rst_frac", 80'(frac_out), 80'(0));
      chk("rst_denorm", 80'(denorm_m), 80'(0));
      chk("rst_sticky", 80'(sticky_out), 80'(0));
      rst = 1'b0;
      send(75'h1234, 10'h382);
      send(75'h1F, 10'h37E);
      send(75'b1 << 74, 10'h338);
      send(75'h5A5A5A5, 10'h338);
      send(75'h7FFF_FFFF_FFFF_FFFF_FFF, 10'h07F);
      send(75'h3, 10'h37D);
      send(75'hFF, 10'h381);
      send(75'h100, 10'h37A);
      send(75'h12345, 10'h200);
      drain();
      // back-pressure in DONE with a competing operand on the input
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(75'hABC, 10'h37E);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("stall_wait_valid", 80'(out_valid), 80'(1));
      in_valid = 1'b1;
      frac_in = 75'h777;
      exp_in = 10'h382;
      k = n_acc;
      repeat (10) begin
         @(negedge clk);
         chk("stall_in_ready", 80'(in_ready), 80'(0));
      end
      in_valid = 1'b0;
      chk("stall_no_accept", 80'(n_acc), 80'(k));
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_valid_low", 80'(out_valid), 80'(0));
      chk("release_in_ready", 80'(in_ready), 80'(1));
      // reset during the second SHIFT cycle of a capped shift
      @(negedge clk);
      in_valid = 1'b1;
      frac_in = 75'b1 << 74;
      exp_in = 10'h338;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      q.delete();
      #1;
      chk("mid_rst_out_valid", 80'(out_valid), 80'(0));
      chk("mid_rst_busy", 80'(busy), 80'(0));
      chk("mid_rst_in_ready", 80'(in_ready), 80'(1));
      chk("mid_rst_outputs", 80'({frac_out, denorm_m, sticky_out}), 80'(0));
      @(negedge clk);
      rst = 1'b0;
      k = n_acc;
      in_valid = 1'b1;
      frac_in = 75'h1F;
      exp_in = 10'h37E;
      @(negedge clk);
      in_valid = 1'b0;
      chk("post_rst_accept", 80'(n_acc), 80'(k + 1));
      drain();
      // randomized traffic with random downstream stalls
      bp = 1;
      for (int i = 0; i < 150; i++) begin
         f = {$urandom, $urandom, 11'($urandom)};
         if ($urandom_range(0, 3) == 0) f = f & 75'h7FF_FFFF;
         x = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'(-100 - int'($urandom_range(0, 40)));
         send(f, x);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bp = 0;
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();
      $display("Simulation finished: %0d checks, %0d errors", chks, errs);
      $finish;
   end
endmodule
